// File: rtl/mcps_pkg.sv
// Shared definitions for the multi-channel packet sender: flag bit positions,
// FSM state encoding and header word layout.
// Header word: [31:24] channel, [23:16] sequence number, [15:0] payload length.
package mcps_pkg;

  localparam int FLAG_SOP = 0;
  localparam int FLAG_EOP = 1;

  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_SEQ_LSB = 16;
  localparam int HDR_CH_LSB  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    GAP  = 2'd3
  } state_e;

  function automatic logic [31:0] mk_hdr(input logic [7:0] ch,
                                         input logic [7:0] seq,
                                         input logic [15:0] len);
    logic [31:0] w;
    w = '0;
    w[HDR_CH_LSB  +: 8]  = ch;
    w[HDR_SEQ_LSB +: 8]  = seq;
    w[HDR_LEN_LSB +: 16] = len;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority request picker; purely combinational, zero latency, no backpressure.
// Ports: req_i (requests), ptr_i (search start in round-robin mode), strict_i
// (search from index 0), grant_valid_o / grant_idx_o (first requester found).
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  input  logic                      strict_i,
  output logic                      grant_valid_o,
  output logic [$clog2(NUM_CH)-1:0] grant_idx_o
);

  localparam int IDX_W = $clog2(NUM_CH);

  always_comb begin
    int start;
    int idx;
    grant_valid_o = |req_i;
    grant_idx_o   = '0;
    start         = strict_i ? 0 : int'(ptr_i);
    idx           = 0;
    // Walk the rotated order from last to first so the earliest hit wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (start + i) % NUM_CH;
      if (req_i[idx]) grant_idx_o = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/multi_channel_packet_sender.sv
// Frames bursts from NUM_CH word FIFOs as packets (header + payload) on a 36-bit stream.
// Latency: first word valid 1 cycle after a request is seen in IDLE; len+2 cycles/packet.
// Backpressure: src_rdy/dst_rdy handshake; word and flags hold while stalled, pops only on accept.
// Ports: clk/reset; fifo_d_i, packet_size_i, fifo_req_i, fifo_rd_o (per-channel FIFO side);
// wr_flags_o, wr_data_o, wr_src_rdy_o, wr_dst_rdy_i (MAC stream); busy_o, active_ch_o (status).
module multi_channel_packet_sender
  import mcps_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int SIZE_W        = 10,
  parameter int MAX_PAYLOAD   = 512,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*32-1:0]     fifo_d_i,
  input  logic [NUM_CH*SIZE_W-1:0] packet_size_i,
  input  logic [NUM_CH-1:0]        fifo_req_i,
  output logic [NUM_CH-1:0]        fifo_rd_o,
  output logic [3:0]               wr_flags_o,
  output logic [31:0]              wr_data_o,
  output logic                     wr_src_rdy_o,
  input  logic                     wr_dst_rdy_i,
  output logic                     busy_o,
  output logic [3:0]               active_ch_o
);

  localparam int   IDX_W  = $clog2(NUM_CH);
  localparam logic STRICT = (PRIORITY_MODE != 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ch_q, ch_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       seq_q [NUM_CH];
  logic [7:0]       seq_d [NUM_CH];

  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic [SIZE_W-1:0] grant_size;
  logic              xfer;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i         (fifo_req_i),
    .ptr_i         (ptr_q),
    .strict_i      (STRICT),
    .grant_valid_o (grant_vld),
    .grant_idx_o   (grant_idx)
  );

  assign grant_size = packet_size_i[int'(grant_idx)*SIZE_W +: SIZE_W];
  assign xfer       = wr_src_rdy_o && wr_dst_rdy_i;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) seq_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          ch_d    = grant_idx;
          // Size is captured once here; later changes on the input are ignored.
          len_d   = (int'(grant_size) > MAX_PAYLOAD) ? 16'(MAX_PAYLOAD) : 16'(grant_size);
          state_d = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          if (len_q == 16'd0) begin
            state_d = GAP;
          end else begin
            cnt_d   = len_q;
            state_d = PAY;
          end
        end
      end
      PAY: begin
        if (xfer) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = GAP;
        end
      end
      GAP: begin
        seq_d[ch_q] = seq_q[ch_q] + 8'd1;
        ptr_d       = (int'(ch_q) + 1 == NUM_CH) ? '0 : ch_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state (plus the pass-through pop and data mux),
  // so a reset cycle forces everything to zero on the following cycle.
  always_comb begin
    wr_src_rdy_o = 1'b0;
    wr_flags_o   = 4'b0000;
    wr_data_o    = '0;
    fifo_rd_o    = '0;
    busy_o       = (state_q != IDLE);
    active_ch_o  = (state_q == IDLE) ? 4'd0 : 4'(ch_q);
    case (state_q)
      HDR: begin
        wr_src_rdy_o         = 1'b1;
        wr_flags_o[FLAG_SOP] = 1'b1;
        wr_flags_o[FLAG_EOP] = (len_q == 16'd0);
        wr_data_o            = mk_hdr(8'(ch_q), seq_q[ch_q], len_q);
      end
      PAY: begin
        wr_src_rdy_o         = 1'b1;
        wr_flags_o[FLAG_EOP] = (cnt_q == 16'd1);
        wr_data_o            = fifo_d_i[int'(ch_q)*32 +: 32];
        fifo_rd_o[ch_q]      = wr_dst_rdy_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_channel_packet_sender.sv
module tb_multi_channel_packet_sender;

  localparam int NUM_CH      = 4;
  localparam int SIZE_W      = 10;
  localparam int MAX_PAYLOAD = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Round-robin instance
  logic [NUM_CH*32-1:0]     fifo_d;
  logic [NUM_CH*SIZE_W-1:0] psize;
  logic [NUM_CH-1:0]        req, rd;
  logic [3:0]               flags, active;
  logic [31:0]              data;
  logic                     src_rdy, dst_rdy, busy;

  // Strict-priority instance
  logic [NUM_CH*32-1:0]     s_d;
  logic [NUM_CH*SIZE_W-1:0] s_size;
  logic [NUM_CH-1:0]        s_req, s_rd;
  logic [3:0]               s_flags, s_active;
  logic [31:0]              s_data;
  logic                     s_src, s_rdy, s_busy;

  multi_channel_packet_sender #(
    .NUM_CH(NUM_CH), .SIZE_W(SIZE_W), .MAX_PAYLOAD(MAX_PAYLOAD), .PRIORITY_MODE(0)
  ) dut (
    .clk(clk), .reset(reset), .fifo_d_i(fifo_d), .packet_size_i(psize),
    .fifo_req_i(req), .fifo_rd_o(rd), .wr_flags_o(flags), .wr_data_o(data),
    .wr_src_rdy_o(src_rdy), .wr_dst_rdy_i(dst_rdy), .busy_o(busy), .active_ch_o(active)
  );

  multi_channel_packet_sender #(
    .NUM_CH(NUM_CH), .SIZE_W(SIZE_W), .MAX_PAYLOAD(MAX_PAYLOAD), .PRIORITY_MODE(1)
  ) dut_strict (
    .clk(clk), .reset(reset), .fifo_d_i(s_d), .packet_size_i(s_size),
    .fifo_req_i(s_req), .fifo_rd_o(s_rd), .wr_flags_o(s_flags), .wr_data_o(s_data),
    .wr_src_rdy_o(s_src), .wr_dst_rdy_i(s_rdy), .busy_o(s_busy), .active_ch_o(s_active)
  );

  // Source FIFOs: channel k presents {k, running word count} and advances on each pop.
  logic [23:0] src_cnt [NUM_CH] = '{default: '0};
  for (genvar k = 0; k < NUM_CH; k++) begin : g_src
    assign fifo_d[k*32 +: 32] = {8'(k), src_cnt[k]};
    assign s_d[k*32 +: 32]    = {8'(k), 24'hABCDE0};
  end
  always @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++)
      if (rd[k]) src_cnt[k] <= src_cnt[k] + 24'd1;
  end

  // Reference model state
  logic [7:0]  seq_m   [NUM_CH];
  logic [23:0] exp_idx [NUM_CH];
  int          ptr_m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NUM_CH-1:0] r, input int p);
    for (int i = 0; i < NUM_CH; i++)
      if (r[(p + i) % NUM_CH]) return (p + i) % NUM_CH;
    return -1;
  endfunction

  function automatic int model_len(input int ch);
    int sz;
    sz = int'(psize[ch*SIZE_W +: SIZE_W]);
    return (sz > MAX_PAYLOAD) ? MAX_PAYLOAD : sz;
  endfunction

  task automatic rand_sizes(input int maxsz);
    for (int k = 0; k < NUM_CH; k++)
      psize[k*SIZE_W +: SIZE_W] = SIZE_W'($urandom_range(0, maxsz));
  endtask

  // Follows one packet from the expected channel through header, payload and gap.
  task automatic run_packet(input int ch, input bit last, input int rdy_pct, input bit chg);
    int          len, w, guard;
    logic [31:0] exp_d;
    logic [3:0]  exp_f;
    logic [NUM_CH-1:0] exp_rd;
    logic        held_vld;
    logic [35:0] held;
    len = model_len(ch);
    w = 0; guard = 0; held_vld = 1'b0; held = '0;
    while (w <= len && guard < 5000) begin
      @(negedge clk);
      dst_rdy = ($urandom_range(0, 99) < rdy_pct);
      #1;
      guard++;
      if (src_rdy) begin
        if (held_vld) chk("hold_stable", {flags, data}, held);
        if (w == 0) begin
          exp_d  = {8'(ch), seq_m[ch], 16'(len)};
          exp_f  = {2'b00, logic'(len == 0), 1'b1};
          exp_rd = '0;
        end else begin
          exp_d  = {8'(ch), exp_idx[ch]};
          exp_f  = {2'b00, logic'(w == len), 1'b0};
          exp_rd = dst_rdy ? NUM_CH'(1 << ch) : '0;
        end
        chk(w == 0 ? "hdr_data" : "pay_data", data, exp_d);
        chk(w == 0 ? "hdr_flags" : "pay_flags", flags, exp_f);
        chk("pop_strobe", rd, exp_rd);
        chk("active_ch", active, ch);
        held_vld = !dst_rdy;
        held     = {flags, data};
        if (dst_rdy) begin
          if (w > 0) exp_idx[ch]++;
          w++;
          if (w == 1 && chg) rand_sizes(15);
        end
      end else begin
        chk("no_pop_idle", rd, 0);
        held_vld = 1'b0;
      end
      @(posedge clk);
    end
    if (guard >= 5000) chk("packet_timeout", 1, 0);
    #1;
    if (last) req = '0;
    @(negedge clk); #1;
    chk("gap_src_rdy", src_rdy, 0);
    chk("gap_busy", busy, 1);
    seq_m[ch] = seq_m[ch] + 8'd1;
    ptr_m     = (ch + 1) % NUM_CH;
  endtask

  initial begin
    int ch, np, pct, guard, n0, n3;
    logic [NUM_CH-1:0] m;
    reset = 1'b1; req = '0; dst_rdy = 1'b0; psize = '0;
    s_req = '0; s_rdy = 1'b1; s_size = '0;
    for (int k = 0; k < NUM_CH; k++) begin seq_m[k] = 8'd0; exp_idx[k] = 24'd0; end
    ptr_m = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_src_rdy", src_rdy, 0);
    chk("rst_flags", flags, 0);
    chk("rst_data", data, 0);
    chk("rst_rd", rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active", active, 0);
    reset = 1'b0;

    // Single channel, size 3, with one-cycle request-to-header latency
    for (int k = 0; k < NUM_CH; k++) psize[k*SIZE_W +: SIZE_W] = SIZE_W'(3);
    req = 4'b0100;
    @(posedge clk); #1;
    chk("lat_src_rdy", src_rdy, 1);
    chk("lat_sop", flags[0], 1);
    run_packet(2, 1'b1, 100, 1'b0);
    chk("pops_ch2", src_cnt[2], 3);

    // Round-robin with all channels requesting, size 2
    for (int k = 0; k < NUM_CH; k++) psize[k*SIZE_W +: SIZE_W] = SIZE_W'(2);
    @(negedge clk);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      ch = pick(req, ptr_m);
      run_packet(ch, i == 7, 100, 1'b0);
    end

    // Edge sizes: zero-length on ch0, clamped oversize on ch3, with backpressure
    psize[0*SIZE_W +: SIZE_W] = SIZE_W'(0);
    psize[3*SIZE_W +: SIZE_W] = SIZE_W'(1023);
    req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      ch = pick(req, ptr_m);
      run_packet(ch, i == 2, 70, 1'b0);
    end
    chk("pops_ch0_zero", src_cnt[0], exp_idx[0]);
    chk("pops_ch3_clamp", src_cnt[3], exp_idx[3]);

    // Randomized phases: request masks, sizes, backpressure, size changes after grant
    for (int p = 0; p < 12; p++) begin
      rand_sizes(12);
      m   = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      np  = $urandom_range(1, 5);
      pct = $urandom_range(30, 100);
      req = m;
      for (int i = 0; i < np; i++) begin
        ch = pick(req, ptr_m);
        run_packet(ch, i == np - 1, pct, 1'b1);
      end
    end
    for (int k = 0; k < NUM_CH; k++) chk("pop_totals", src_cnt[k], exp_idx[k]);

    // Reset in the middle of a payload
    psize[1*SIZE_W +: SIZE_W] = SIZE_W'(10);
    dst_rdy = 1'b1;
    req = 4'b0010;
    guard = 0;
    do begin
      @(negedge clk); #1; guard++;
    end while (!(src_rdy && flags[0]) && guard < 50);
    if (guard >= 50) chk("hdr_wait_timeout", 1, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_src_rdy", src_rdy, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_data", data, 0);
    chk("midrst_rd", rd, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_active", active, 0);
    req = '0;
    for (int k = 0; k < NUM_CH; k++) seq_m[k] = 8'd0;
    ptr_m = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NUM_CH; k++) exp_idx[k] = src_cnt[k];

    // Sequence number restart and 255 -> 0 wrap on ch1 (257 zero-length packets)
    psize[1*SIZE_W +: SIZE_W] = SIZE_W'(0);
    req = 4'b0010;
    for (int i = 0; i < 257; i++) run_packet(1, i == 256, 100, 1'b0);

    // Strict priority: ch0 always beats ch3 while both request
    for (int k = 0; k < NUM_CH; k++) s_size[k*SIZE_W +: SIZE_W] = SIZE_W'(1);
    n0 = 0; n3 = 0;
    @(negedge clk);
    s_req = 4'b1001;
    repeat (80) begin
      @(negedge clk); #1;
      if (s_src && s_flags[0]) begin
        if (s_data[31:24] == 8'd0) n0++;
        else if (s_data[31:24] == 8'd3) n3++;
      end
    end
    chk("strict_ch3_starved", n3, 0);
    chk("strict_ch0_served", n0 >= 15, 1);
    s_req = 4'b1000;
    n3 = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (s_src && s_flags[0] && s_data[31:24] == 8'd3) n3++;
    end
    chk("strict_ch3_alone", n3 >= 5, 1);
    s_req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
